// File: rtl/out_port_serial_tx.sv
// Captures CPU output-port writes into a FIFO and serialises them as UART frames on txd.
// Define OUT_PORT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module out_port_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       doOut,
   input  logic [7:0] dbus,
   output logic       txd,
   output logic       busy,
   output logic       full,
   output logic       overflow
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [7:0]    DivLast = 8'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] Depth   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef OUT_PORT_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    div_q, div_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          overflow_q, overflow_d;
`ifdef OUT_PORT_PARITY_EN
   logic          parity_q, parity_d;
`endif
   logic          bit_end, pop, push;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      overflow_d = overflow_q;
`ifdef OUT_PORT_PARITY_EN
      parity_d   = parity_q;
`endif

      bit_end = (div_q == DivLast);
      // A pop happens from IDLE, or at the end of STOP to chain frames without a gap.
      pop  = (count_q != '0) && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
      push = doOut && ((count_q != Depth) || pop);

      if (state_q != StIdle) begin
         div_d = bit_end ? '0 : div_q + 8'd1;
      end

      case (state_q)
         StIdle: ;
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               bit_idx_d = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef OUT_PORT_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef OUT_PORT_PARITY_EN
         StParity: begin
            if (bit_end) state_d = StStop;
         end
`endif
         StStop: begin
            if (bit_end) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         state_d  = StStart;
         div_d    = '0;
         shift_d  = fifo_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef OUT_PORT_PARITY_EN
         parity_d = ^fifo_q[rd_ptr_q];
`endif
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else if (doOut) begin
         overflow_d = 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         div_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef OUT_PORT_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) parity_q <= 1'b0;
      else       parity_q <= parity_d;
   end
`endif

   // Storage needs no reset; count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= dbus;
   end

   always_comb begin
      case (state_q)
         StIdle:   txd = 1'b1;
         StStart:  txd = 1'b0;
         StData:   txd = shift_q[0];
`ifdef OUT_PORT_PARITY_EN
         StParity: txd = parity_q;
`endif
         StStop:   txd = 1'b1;
         default:  txd = 1'b1;
      endcase
   end

   assign busy     = (state_q != StIdle) || (count_q != '0);
   assign full     = (count_q == Depth);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_out_port_serial_tx.sv
// Bench for out_port_serial_tx: directed vector table, corner sequences and random traffic
// checked every cycle against a timeline/queue model of the serial line.
module tb_out_port_serial_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef OUT_PORT_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int FLEN = FRAME * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       doOut;
   logic [7:0] dbus;
   logic       txd, busy, full, overflow;

   always #5 clk = ~clk;

   out_port_serial_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .doOut    (doOut),
      .dbus     (dbus),
      .txd      (txd),
      .busy     (busy),
      .full     (full),
      .overflow (overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_start  = 0;
   logic [7:0] m_byte   = 8'h00;
   bit         m_ovf    = 1'b0;

   int         rx_cnt   = -1;
   logic [7:0] rx_shift = 8'h00;
   logic [7:0] rx_q[$];

   typedef struct {
      logic       do_out;
      logic [7:0] data;
      int         cycles;
      logic       exp_txd;
      logic       exp_busy;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   // Line level follows from the elapsed time since the frame's pop edge.
   function automatic logic model_txd();
      int pos;
      if (!m_active) return 1'b1;
      pos = (cyc - m_start) / CPB;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return m_byte[pos-1];
      if (FRAME == 11 && pos == 9) return ^m_byte;
      return 1'b1;
   endfunction

   task automatic tick(input logic r, input logic d, input logic [7:0] b);
      @(negedge clk);
      reset = r;
      doOut = d;
      dbus  = b;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_q.delete();
         m_active = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         if (m_active && (cyc - m_start == FLEN)) m_active = 1'b0;
         if (!m_active && m_q.size() > 0) begin
            m_byte   = m_q.pop_front();
            m_start  = cyc;
            m_active = 1'b1;
         end
         if (d) begin
            if (int'(m_q.size()) < DEPTH) m_q.push_back(b);
            else m_ovf = 1'b1;
         end
      end
      #1;
      check("txd", 32'(txd), 32'(model_txd()));
      check("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
      check("full", 32'(full), 32'(int'(m_q.size()) == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      // Independent receiver decoding the DUT line mid-bit.
      if (r) begin
         rx_cnt = -1;
      end else if (rx_cnt >= 0) begin
         rx_cnt++;
         for (int k = 0; k < 8; k++) begin
            if (rx_cnt == (k + 1) * CPB + CPB / 2) rx_shift[k] = txd;
         end
         if (rx_cnt == (FRAME - 1) * CPB + CPB / 2) begin
            check("rx_stop_bit", 32'(txd), 32'd1);
            rx_q.push_back(rx_shift);
            rx_cnt = -1;
         end
      end else if (txd == 1'b0) begin
         rx_cnt = 0;
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (busy && n < max) begin
         tick(1'b0, 1'b0, 8'h00);
         n++;
      end
      check("drain_done", 32'(busy), 32'd0);
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp[$]);
      check({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
      if (rx_q.size() == exp.size()) begin
         for (int i = 0; i < exp.size(); i++) check({name, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         run;
      logic [7:0] exp_bytes[$];
      reset = 1'b1;
      doOut = 1'b0;
      dbus  = 8'h00;

      tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, 8'h5A);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      tick(1'b0, 1'b0, 8'hFF);
      check("idle_ignores_dbus", 32'(busy), 32'd0);

      // 0x41 frame: start, bits 1,0,0,0,0,0,1,0, [parity 0], stop, then idle.
      vecs.push_back('{1'b1, 8'h41, 1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 20, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1});
`ifdef OUT_PORT_PARITY_EN
      vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1});
`endif
      vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 3, 1'b1, 1'b0});
      rx_q.delete();
      for (int v = 0; v < vecs.size(); v++) begin
         for (int c = 0; c < vecs[v].cycles; c++) begin
            tick(1'b0, vecs[v].do_out && (c == 0), vecs[v].data);
            check("vec_txd", 32'(txd), 32'(vecs[v].exp_txd));
            check("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
         end
      end
      exp_bytes = '{8'h41};
      check_rx("rx_41", exp_bytes);

      // Two back-to-back frames, busy contiguous for both.
      rx_q.delete();
      run = 0;
      tick(1'b0, 1'b1, 8'h55);
      if (busy) run++;
      tick(1'b0, 1'b1, 8'hAA);
      if (busy) run++;
      for (int i = 0; i < 3 * FLEN && busy; i++) begin
         tick(1'b0, 1'b0, 8'h00);
         if (busy) run++;
      end
      check("busy_run_2frames", 32'(run), 32'(2 * FLEN + 1));
      exp_bytes = '{8'h55, 8'hAA};
      check_rx("rx_55aa", exp_bytes);

      // Overflow: six pushes into a depth-4 FIFO while the first frame starts.
      rx_q.delete();
      for (int i = 1; i <= 6; i++) begin
         tick(1'b0, 1'b1, 8'(i));
         if (i == 4) check("full_after4", 32'(full), 32'd0);
         if (i == 5) check("full_after5", 32'(full), 32'd1);
         if (i == 5) check("no_ovf_after5", 32'(overflow), 32'd0);
         if (i == 6) check("ovf_after6", 32'(overflow), 32'd1);
      end
      drain(6 * FLEN);
      check("ovf_sticky", 32'(overflow), 32'd1);
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_rx("rx_ovf", exp_bytes);

      // Reset 12 cycles into a 0xFF frame with two bytes queued.
      rx_q.delete();
      tick(1'b0, 1'b1, 8'hFF);
      tick(1'b0, 1'b1, 8'h11);
      tick(1'b0, 1'b1, 8'h22);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);
      tick(1'b1, 1'b0, 8'h00);
      check("midrst_txd", 32'(txd), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_full", 32'(full), 32'd0);
      for (int i = 0; i < 3 * FLEN; i++) tick(1'b0, 1'b0, 8'h00);
      check("midrst_no_frames", 32'(rx_q.size()), 32'd0);

      // Push on the exact edge the last STOP bit ends.
      rx_q.delete();
      tick(1'b0, 1'b1, 8'h3C);
      for (int i = 0; i < FLEN; i++) tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'hC3);
      check("stopedge_busy", 32'(busy), 32'd1);
      tick(1'b0, 1'b0, 8'h00);
      check("stopedge_start", 32'(txd), 32'd0);
      drain(2 * FLEN);
      exp_bytes = '{8'h3C, 8'hC3};
      check_rx("rx_stopedge", exp_bytes);

`ifdef OUT_PORT_PARITY_EN
      // Parity bit values and 11-bit frame length.
      for (int p = 0; p < 2; p++) begin
         run = 0;
         tick(1'b0, 1'b1, (p == 0) ? 8'h07 : 8'h03);
         if (busy) run++;
         for (int i = 0; i < 9 * CPB + 2; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            if (busy) run++;
         end
         check("parity_bit", 32'(txd), (p == 0) ? 32'd1 : 32'd0);
         for (int i = 0; i < 2 * FLEN && busy; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            if (busy) run++;
         end
         check("parity_frame_len", 32'(run), 32'(FLEN + 1));
      end
`endif

      // Random traffic in phases of varying write density, with rare resets.
      for (int ph = 0; ph < 3; ph++) begin
         int dens;
         dens = (ph == 0) ? 3 : ((ph == 1) ? 20 : 60);
         for (int i = 0; i < 1200; i++) begin
            tick(($urandom_range(0, 599) == 0), ($urandom_range(0, dens - 1) == 0),
                 8'($urandom));
         end
      end
      drain(8 * FLEN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
